// File: rtl/pwm_peripheral.sv
// 16-channel output stage with a shared 8-bit PWM waveform.
// Duty updates are shadowed and only take effect at the period wrap.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PrescMax = 16'(CLK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [15:0] en_out, en_pwm, out_d;
  logic        tick, wrap, pwm_sig, period_start_d;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (presc_q == PrescMax);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  always_comb begin
    presc_d        = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_sh_d      = wrap ? pwm_duty_cycle : duty_sh_q;
    // 0xFF is special-cased so full duty has no low count at the end of the period
    pwm_sig        = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
    out_d          = en_out & (~en_pwm | {16{pwm_sig}});
    period_start_d = (pwm_cnt_q == 8'd0) && (presc_q == 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= 16'd0;
      pwm_cnt_q    <= 8'd0;
      duty_sh_q    <= 8'd0;
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_sh_q    <= duty_sh_d;
      out          <= out_d;
      period_start <= period_start_d;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized bench for pwm_peripheral: two instances (CLK_DIV 2 and 1) checked
// every cycle against a model that derives outputs from the elapsed cycle count.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;

  logic [15:0] out2, out1;
  logic        ps2, ps1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(2)) u_dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out2),
    .period_start    (ps2)
  );

  pwm_peripheral #(.CLK_DIV(1)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out1),
    .period_start    (ps1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output after clock edge number n (0 = first edge after reset release).
  function automatic logic [15:0] model_out(int unsigned n, int unsigned d, logic [7:0] dc,
                                            logic [15:0] eo, logic [15:0] ep);
    int unsigned count;
    logic hi;
    count = (n % (256 * d)) / d;
    hi = (dc == 8'hFF) || (count < int'(dc));
    return eo & (~ep | {16{hi}});
  endfunction

  // Reference state: edges since reset and the duty owned by the current period.
  int unsigned m2_n = 0, m1_n = 0;
  logic [7:0]  m2_duty = '0, m1_duty = '0;
  logic [15:0] exp2 = '0, exp1 = '0;
  logic        exp_ps2 = 1'b0, exp_ps1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_n <= 0; m2_duty <= '0; exp2 <= '0; exp_ps2 <= 1'b0;
    end else begin
      exp2    <= model_out(m2_n, 2, m2_duty, en_out, en_pwm);
      exp_ps2 <= (m2_n % 512) == 0;
      m2_n    <= m2_n + 1;
      if (((m2_n + 1) % 512) == 0) m2_duty <= duty;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_n <= 0; m1_duty <= '0; exp1 <= '0; exp_ps1 <= 1'b0;
    end else begin
      exp1    <= model_out(m1_n, 1, m1_duty, en_out, en_pwm);
      exp_ps1 <= (m1_n % 256) == 0;
      m1_n    <= m1_n + 1;
      if (((m1_n + 1) % 256) == 0) m1_duty <= duty;
    end
  end

  always @(negedge clk) begin
    check("out_div2", 32'(out2), 32'(exp2));
    check("ps_div2", 32'(ps2), 32'(exp_ps2));
    check("out_div1", 32'(out1), 32'(exp1));
    check("ps_div1", 32'(ps1), 32'(exp_ps1));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the next period start on the selected instance, then count high cycles of out[0].
  task automatic measure_high(input int d, input int expected, input string tag);
    int found = 0;
    int highs = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge clk);
      if ((d == 2) ? ps2 : ps1) found = 1;
    end
    check({tag, "_ps_seen"}, 32'(found), 32'd1);
    if (found != 0) begin
      for (int i = 0; i < 256 * d; i++) begin
        if ((d == 2) ? out2[0] : out1[0]) highs++;
        @(negedge clk);
      end
      check({tag, "_highs"}, 32'(highs), 32'(expected));
    end
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_div2", 32'(out2), 32'h0);
    check("rst_ps_div2", 32'(ps2), 32'h0);
    check("rst_out_div1", 32'(out1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_phase2(input int unsigned pos);
    int ok = 0;
    for (int i = 0; i < 1200 && ok == 0; i++) begin
      @(negedge clk);
      if ((m2_n % 512) == pos) ok = 1;
    end
    check("phase_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    run(3);
    rst_n = 1'b1;
    run(300);
    async_reset_pulse();
    // First period after reset has no duty loaded: everything stays low.
    measure_high(2, 0, "first_period_div2");
    measure_high(2, 256, "duty80_div2");

    duty = 8'h00; measure_high(1, 0, "duty00_div1"); measure_high(1, 0, "duty00_div1_b");
    duty = 8'hFF; measure_high(1, 256, "dutyFF_div1");
    duty = 8'h01; measure_high(1, 1, "duty01_div1");
    duty = 8'h80; measure_high(2, 256, "duty80_div2_b");

    en_out = 16'h00F0;
    en_pwm = 16'h0030;
    duty   = 8'h40;
    run(1100);
    en_out = 16'h0000;
    run(2);
    check("en_off_out", 32'(out2), 32'h0);

    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h40;
    run(1100);
    wait_phase2(32'h20);
    duty = 8'hC0;
    measure_high(2, 384, "glitch_mid_div2");
    duty = 8'h40;
    run(1100);
    wait_phase2(511);
    duty = 8'hC0;
    measure_high(2, 384, "glitch_wrap_div2");

    for (int it = 0; it < 30; it++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      duty   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) async_reset_pulse();
      run($urandom_range(1, 700));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
